// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder: accepts word-aligned masked read/write requests, stalls
// for WAIT_STATES cycles, then commits the write or returns registered read data.
module msrv32_dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic        ms_riscv32_mp_dmrd_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic        ahb_ready_out,
  output logic        dmem_resp_valid_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        dmem_err_out
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [31:0]           data_r;
  logic [3:0]            mask_r;
  logic                  op_wr_r;
  logic                  op_rd_r;
  logic                  oor_r;
  logic [31:0]           mem_r [0:DEPTH-1];

  logic                  accept_s;
  logic                  addr_oor_s;
  logic [ADDR_WIDTH-1:0] addr_idx_s;
  logic                  enter_resp_s;
  logic [ADDR_WIDTH-1:0] commit_idx_s;
  logic [31:0]           commit_data_s;
  logic [3:0]            commit_mask_s;
  logic                  commit_wr_s;
  logic                  commit_rd_s;
  logic                  commit_oor_s;

  assign accept_s   = (state_r == ST_IDLE) && (ahb_htrans_in != 2'b00) &&
                      (ms_riscv32_mp_dmwr_req_in || ms_riscv32_mp_dmrd_req_in);
  assign addr_oor_s = (ms_riscv32_mp_dmaddr_in >> (ADDR_WIDTH + 2)) != 32'd0;
  assign addr_idx_s = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];

  // With zero wait states the commit edge is the accept edge, so take the live request.
  assign commit_idx_s  = accept_s ? addr_idx_s : idx_r;
  assign commit_data_s = accept_s ? ms_riscv32_mp_dmdata_in : data_r;
  assign commit_mask_s = accept_s ? ms_riscv32_mp_dmwr_mask_in : mask_r;
  assign commit_wr_s   = accept_s ? ms_riscv32_mp_dmwr_req_in : op_wr_r;
  assign commit_rd_s   = accept_s ? (ms_riscv32_mp_dmrd_req_in && !ms_riscv32_mp_dmwr_req_in) : op_rd_r;
  assign commit_oor_s  = accept_s ? addr_oor_s : oor_r;
  assign enter_resp_s  = (state_nxt_s == ST_RESP);

  // Next-state and wait counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES > 0) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, request capture and registered handshake outputs.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_r                  <= ST_IDLE;
      cnt_r                    <= 4'd0;
      idx_r                    <= '0;
      data_r                   <= 32'd0;
      mask_r                   <= 4'd0;
      op_wr_r                  <= 1'b0;
      op_rd_r                  <= 1'b0;
      oor_r                    <= 1'b0;
      ahb_ready_out            <= 1'b1;
      dmem_resp_valid_out      <= 1'b0;
      dmem_err_out             <= 1'b0;
      ms_riscv32_mp_dmdata_out <= 32'd0;
    end else begin
      state_r             <= state_nxt_s;
      cnt_r               <= cnt_nxt_s;
      ahb_ready_out       <= (state_nxt_s != ST_WAIT);
      dmem_resp_valid_out <= enter_resp_s;
      dmem_err_out        <= enter_resp_s && commit_oor_s;
      if (accept_s) begin
        idx_r   <= addr_idx_s;
        data_r  <= ms_riscv32_mp_dmdata_in;
        mask_r  <= ms_riscv32_mp_dmwr_mask_in;
        op_wr_r <= ms_riscv32_mp_dmwr_req_in;
        op_rd_r <= ms_riscv32_mp_dmrd_req_in && !ms_riscv32_mp_dmwr_req_in;
        oor_r   <= addr_oor_s;
      end
      if (enter_resp_s && commit_rd_s) begin
        ms_riscv32_mp_dmdata_out <= commit_oor_s ? 32'd0 : mem_r[commit_idx_s];
      end
    end
  end

  // Word array; reset wins over a write committing on the same edge.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in && enter_resp_s && commit_wr_s && !commit_oor_s) begin
      mem_r[commit_idx_s] <= merge_bytes(mem_r[commit_idx_s], commit_data_s, commit_mask_s);
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Randomized self-checking bench: two responders (1 and 0 wait states) against a
// word-array reference model with byte-lane merging and fixed completion latency.
module tb_msrv32_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [3:0]  dm_mask = 4'd0;
  logic        dm_wr = 1'b0;
  logic        dm_rd = 1'b0;
  logic [1:0]  htrans_a = 2'b00;
  logic [1:0]  htrans_b = 2'b00;
  logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
  logic [31:0] rdat_a, rdat_b;

  int tot = 0;
  int bad = 0;
  bit sel_g = 1'b0;
  logic [31:0] mem_m [2][1024];
  logic [31:0] last_m [2];
  logic [31:0] rd_v;
  logic        er_v;

  logic        cur_rdy, cur_vld, cur_err;
  logic [31:0] cur_rdat;
  assign cur_rdy  = sel_g ? rdy_b  : rdy_a;
  assign cur_vld  = sel_g ? vld_b  : vld_a;
  assign cur_err  = sel_g ? err_b  : err_a;
  assign cur_rdat = sel_g ? rdat_b : rdat_a;

  always #5 clk = ~clk;

  msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(dm_addr), .ms_riscv32_mp_dmdata_in(dm_wdata),
    .ms_riscv32_mp_dmwr_mask_in(dm_mask), .ms_riscv32_mp_dmwr_req_in(dm_wr),
    .ms_riscv32_mp_dmrd_req_in(dm_rd), .ahb_htrans_in(htrans_a),
    .ahb_ready_out(rdy_a), .dmem_resp_valid_out(vld_a),
    .ms_riscv32_mp_dmdata_out(rdat_a), .dmem_err_out(err_a));

  msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .ms_riscv32_mp_dmaddr_in(dm_addr), .ms_riscv32_mp_dmdata_in(dm_wdata),
    .ms_riscv32_mp_dmwr_mask_in(dm_mask), .ms_riscv32_mp_dmwr_req_in(dm_wr),
    .ms_riscv32_mp_dmrd_req_in(dm_rd), .ahb_htrans_in(htrans_b),
    .ahb_ready_out(rdy_b), .dmem_resp_valid_out(vld_b),
    .ms_riscv32_mp_dmdata_out(rdat_b), .dmem_err_out(err_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_req();
    dm_wr    = 1'b0;
    dm_rd    = 1'b0;
    htrans_a = 2'b00;
    htrans_b = 2'b00;
  endtask

  // One transfer on instance sel, checked against the reference model.
  task automatic xfer(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input bit wr, input bit rd,
                      output logic [31:0] rdata, output logic err);
    int lat;
    bit got;
    bit oor;
    int idx;
    logic [31:0] exp_d;
    sel_g = sel;
    @(negedge clk);
    check("rdy_idle", {31'd0, cur_rdy}, 32'd1);
    dm_addr  = addr;
    dm_wdata = data;
    dm_mask  = mask;
    dm_wr    = wr;
    dm_rd    = rd;
    if (sel) htrans_b = 2'b10;
    else     htrans_a = 2'b10;
    @(posedge clk);
    #1;
    clear_req();
    got = 1'b0;
    lat = 1;
    while (!got && lat <= 20) begin
      if (cur_vld === 1'b1) begin
        got = 1'b1;
      end else begin
        check("rdy_wait", {31'd0, cur_rdy}, 32'd0);
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    rdata = cur_rdat;
    err   = cur_err;

    oor = (addr >= 32'h0000_1000);
    idx = int'(addr[11:2]);
    if (wr) begin
      exp_d = last_m[sel];
      if (!oor) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) mem_m[sel][idx][8*i +: 8] = data[8*i +: 8];
        end
      end
    end else begin
      exp_d = oor ? 32'd0 : mem_m[sel][idx];
      last_m[sel] = exp_d;
    end
    check("latency", lat, sel ? 32'd1 : 32'd2);
    check("rdy_resp", {31'd0, cur_rdy}, 32'd1);
    check("err", {31'd0, err}, {31'd0, oor});
    check("rdata", rdata, exp_d);

    @(posedge clk);
    #1;
    check("vld_drop", {31'd0, cur_vld}, 32'd0);
    check("err_drop", {31'd0, cur_err}, 32'd0);
  endtask

  initial begin
    clear_req();
    last_m[0] = 32'd0;
    last_m[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_a", {31'd0, rdy_a}, 32'd1);
    check("rst_vld_a", {31'd0, vld_a}, 32'd0);
    check("rst_err_a", {31'd0, err_a}, 32'd0);
    check("rst_dat_a", rdat_a, 32'd0);
    check("rst_dat_b", rdat_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full word write then read.
    xfer(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t1_read", rd_v, 32'hDEADBEEF);
    // Single byte lane, then an empty mask.
    xfer(1'b0, 32'h10, 32'h0000AB00, 4'b0010, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b0, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t2_read", rd_v, 32'hDEADABEF);
    // Halfword with unaligned low bits.
    xfer(1'b0, 32'h12, 32'h12340000, 4'b1100, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t3_read", rd_v, 32'h1234ABEF);
    // Out of range must not alias onto word 0.
    xfer(1'b0, 32'h0, 32'h11111111, 4'hF, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b0, 32'h00001000, 32'h99999999, 4'hF, 1'b1, 1'b0, rd_v, er_v);
    check("t4_werr", {31'd0, er_v}, 32'd1);
    xfer(1'b0, 32'h00001000, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t4_rerr", {31'd0, er_v}, 32'd1);
    check("t4_rdat", rd_v, 32'd0);
    xfer(1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t4_word0", rd_v, 32'h11111111);

    // Reset lands on the commit edge of a pending write.
    xfer(1'b0, 32'h20, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, rd_v, er_v);
    @(negedge clk);
    dm_addr = 32'h20; dm_wdata = 32'hCAFEF00D; dm_mask = 4'hF; dm_wr = 1'b1; htrans_a = 2'b10;
    @(posedge clk);
    #1;
    clear_req();
    check("t5_wait", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rdy", {31'd0, rdy_a}, 32'd1);
    check("t5_vld", {31'd0, vld_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_m[0] = 32'd0;
    last_m[1] = 32'd0;
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t5_read", rd_v, 32'h55AA55AA);

    // Idle htrans with a request pending must not be accepted.
    sel_g = 1'b0;
    @(negedge clk);
    dm_addr = 32'h20; dm_wdata = 32'h0BADF00D; dm_mask = 4'hF; dm_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t6_idle_rdy", {31'd0, rdy_a}, 32'd1);
      check("t6_idle_vld", {31'd0, vld_a}, 32'd0);
    end
    clear_req();
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t6_idle_data", rd_v, 32'h55AA55AA);

    // Zero wait states; write+read together behaves as write.
    xfer(1'b1, 32'h10, 32'h01020304, 4'hF, 1'b1, 1'b0, rd_v, er_v);
    xfer(1'b1, 32'h10, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    xfer(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b1, rd_v, er_v);
    check("t6_both_hold", rd_v, 32'h01020304);
    xfer(1'b1, 32'h10, 32'd0, 4'h0, 1'b0, 1'b1, rd_v, er_v);
    check("t6_both_data", rd_v, 32'hA5A5A5A5);

    // Seed a small address pool on both instances, then random traffic.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 8; w++) begin
        xfer(s[0], 32'h100 + 32'(w * 4), $urandom(), 4'hF, 1'b1, 1'b0, rd_v, er_v);
      end
    end
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      int op;
      a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h0000_1000;
      op = $urandom_range(0, 2);
      xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
           op != 1, op != 0, rd_v, er_v);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
